// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: turns an AXI-stream byte stream into a GMII frame
// made of preamble, SFD, payload, optional zero padding and FCS, followed
// by an inter-frame gap. All GMII outputs are registered. The byte accepted
// on the stream in cycle k appears on gmii_txd in cycle k+1.
module gmii_tx_framer #(
    parameter int ENABLE_PADDING   = 1,
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int IFG_CYCLES       = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       start_packet,
    output logic       error_underflow
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, PAYLOAD, PAD, FCS, DISCARD, IFG
    } state_t;

    // Payload bytes needed so that payload plus FCS reaches the minimum frame.
    localparam logic [15:0] MIN_PAYLOAD = 16'(MIN_FRAME_LENGTH - 4);
    localparam logic [7:0]  IFG_LAST    = 8'(IFG_CYCLES);
    localparam logic [7:0]  PRE_LAST    = 8'd6;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  ph_q, ph_d;
    logic [7:0]  txd_q, txd_d;
    logic        en_q, en_d;
    logic        er_q, er_d;
    logic        sp_q, sp_d;
    logic        uf_q, uf_d;
    logic        beat;
    logic [15:0] cnt_inc;
    logic [31:0] crc_inv;

    // One byte of the reflected CRC-32 (poly 0xEDB88320), LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign s_axis_tready = (state_q == PAYLOAD) || (state_q == DISCARD);
    assign beat          = s_axis_tvalid & s_axis_tready;
    // Frame byte count saturates so oversized frames never wrap into padding.
    assign cnt_inc       = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign crc_inv       = ~crc_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (s_axis_tvalid) state_d = PREAMBLE;
            PREAMBLE: if (ph_q == PRE_LAST) state_d = PAYLOAD;
            PAYLOAD: begin
                if (!s_axis_tvalid) begin
                    state_d = DISCARD;
                end else if (s_axis_tlast) begin
                    if (s_axis_tuser) begin
                        state_d = IFG;
                    end else if ((ENABLE_PADDING != 0) && (cnt_inc < MIN_PAYLOAD)) begin
                        state_d = PAD;
                    end else begin
                        state_d = FCS;
                    end
                end
            end
            PAD:      if (cnt_inc >= MIN_PAYLOAD) state_d = FCS;
            FCS:      if (ph_q == 8'd3) state_d = IFG;
            DISCARD:  if (beat && s_axis_tlast) state_d = IFG;
            IFG:      if (ph_q == IFG_LAST) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Next values for the GMII outputs, CRC, byte count and phase counter.
    always_comb begin
        txd_d = 8'h00;
        en_d  = 1'b0;
        er_d  = 1'b0;
        sp_d  = 1'b0;
        uf_d  = 1'b0;
        crc_d = crc_q;
        cnt_d = cnt_q;
        // Phase counter restarts on every state change.
        ph_d  = (state_d == state_q) ? ph_q + 8'd1 : 8'd0;
        case (state_q)
            IDLE: begin
                crc_d = 32'hFFFFFFFF;
                cnt_d = 16'd0;
                if (s_axis_tvalid) begin
                    en_d  = 1'b1;
                    txd_d = 8'h55;
                end
            end
            PREAMBLE: begin
                en_d = 1'b1;
                if (ph_q == PRE_LAST) begin
                    txd_d = 8'hD5;
                    sp_d  = 1'b1;
                end else begin
                    txd_d = 8'h55;
                end
            end
            PAYLOAD: begin
                en_d = 1'b1;
                if (s_axis_tvalid) begin
                    txd_d = s_axis_tdata;
                    er_d  = s_axis_tlast & s_axis_tuser;
                    crc_d = crc32_byte(crc_q, s_axis_tdata);
                    cnt_d = cnt_inc;
                end else begin
                    // Source ran dry mid-frame: poison the frame on the wire.
                    er_d = 1'b1;
                    uf_d = 1'b1;
                end
            end
            PAD: begin
                en_d  = 1'b1;
                crc_d = crc32_byte(crc_q, 8'h00);
                cnt_d = cnt_inc;
            end
            FCS: begin
                en_d  = 1'b1;
                txd_d = crc_inv[{ph_q[1:0], 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 32'hFFFFFFFF;
            cnt_q <= 16'd0;
            ph_q  <= 8'd0;
            txd_q <= 8'h00;
            en_q  <= 1'b0;
            er_q  <= 1'b0;
            sp_q  <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            crc_q <= crc_d;
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
            txd_q <= txd_d;
            en_q  <= en_d;
            er_q  <= er_d;
            sp_q  <= sp_d;
            uf_q  <= uf_d;
        end
    end

    assign gmii_txd        = txd_q;
    assign gmii_tx_en      = en_q;
    assign gmii_tx_er      = er_q;
    assign start_packet    = sp_q;
    assign error_underflow = uf_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: one padding instance, one non-padding
// instance, output activity logged per cycle and checked after each frame.
module tb_gmii_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser;
    logic       sel;

    logic       rdy_a, en_a, er_a, sp_a, uf_a;
    logic [7:0] txd_a;
    logic       rdy_b, en_b, er_b, sp_b, uf_b;
    logic [7:0] txd_b;
    logic       rdy, en, er, sp, uf;
    logic [7:0] txd;

    int n_vec = 0;
    int n_bad = 0;

    always #4 clk = ~clk;

    gmii_tx_framer #(.ENABLE_PADDING(1), .MIN_FRAME_LENGTH(64), .IFG_CYCLES(12)) dut_pad (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & ~sel), .s_axis_tready(rdy_a),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .gmii_txd(txd_a), .gmii_tx_en(en_a), .gmii_tx_er(er_a),
        .start_packet(sp_a), .error_underflow(uf_a)
    );

    gmii_tx_framer #(.ENABLE_PADDING(0), .MIN_FRAME_LENGTH(64), .IFG_CYCLES(12)) dut_nopad (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & sel), .s_axis_tready(rdy_b),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .gmii_txd(txd_b), .gmii_tx_en(en_b), .gmii_tx_er(er_b),
        .start_packet(sp_b), .error_underflow(uf_b)
    );

    assign rdy = sel ? rdy_b : rdy_a;
    assign en  = sel ? en_b  : en_a;
    assign er  = sel ? er_b  : er_a;
    assign sp  = sel ? sp_b  : sp_a;
    assign uf  = sel ? uf_b  : uf_a;
    assign txd = sel ? txd_b : txd_a;

    // Per-cycle log of the selected instance, sampled on the falling edge.
    int         cyc = 0;
    logic [7:0] txd_log [0:4095];
    logic       en_log  [0:4095];
    logic       er_log  [0:4095];
    logic       sp_log  [0:4095];
    logic       uf_log  [0:4095];
    logic       rdy_log [0:4095];

    always @(negedge clk) begin
        if (cyc < 4096) begin
            txd_log[cyc] <= txd;
            en_log[cyc]  <= en;
            er_log[cyc]  <= er;
            sp_log[cyc]  <= sp;
            uf_log[cyc]  <= uf;
            rdy_log[cyc] <= rdy;
        end
        cyc <= cyc + 1;
    end

    logic [7:0]  pl   [0:127];
    logic [7:0]  refb [0:63];
    logic [31:0] exp_fcs;

    localparam int S_EN = 0, S_ER = 1, S_SP = 2, S_UF = 3, S_RDY = 4;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int count_sig(input int which, input int a, input int b);
        int n;
        n = 0;
        for (int k = a; k <= b; k++) begin
            case (which)
                S_EN:    n += int'(en_log[k]);
                S_ER:    n += int'(er_log[k]);
                S_SP:    n += int'(sp_log[k]);
                S_UF:    n += int'(uf_log[k]);
                default: n += int'(rdy_log[k]);
            endcase
        end
        return n;
    endfunction

    function automatic int first_en(input int a, input int b);
        for (int k = a; k <= b; k++) begin
            if (en_log[k]) return k;
        end
        return -1;
    endfunction

    // Bit-serial reference CRC-32 over refb[0..n-1]; returns the FCS value.
    function automatic logic [31:0] ref_fcs(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ refb[i][b];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Streams pl[0..n-1]; optionally withholds tvalid for gap_len cycles
    // once gap_at bytes have gone. Called and returns at posedge+1.
    task automatic send_frame(input int n, input bit abort, input int gap_at, input int gap_len,
                              output int first, output int last);
        int i, gap, guard, cur;
        i = 0; gap = 0; guard = 0;
        first = cyc; last = -1;
        while (i < n && guard < 3000) begin
            cur = cyc;
            if (i == gap_at && gap < gap_len) begin
                tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
                gap++;
            end else begin
                tvalid = 1'b1;
                tdata  = pl[i];
                tlast  = (i == n - 1);
                tuser  = abort && (i == n - 1);
            end
            @(negedge clk);
            if (tvalid && rdy) begin
                if (i == n - 1) last = cur;
                i++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        chk("send_all", i, n);
    endtask

    initial begin : main
        int s, l, s2, l2, s3, l3, s4, l4, s5, l5, s7, l7, r, r5, acc, guard;

        rst = 1'b1; tvalid = 1'b0; tdata = 8'h00; tlast = 1'b0; tuser = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pad",   {en_a, er_a, sp_a, uf_a, rdy_a, txd_a}, 0);
        chk("reset_nopad", {en_b, er_b, sp_b, uf_b, rdy_b, txd_b}, 0);
        rst = 1'b0;
        wait_cycles(2);

        // Minimum padded frame, 10 bytes 0x01..0x0A; also the latency checks.
        for (int i = 0; i < 10; i++) pl[i] = 8'(i + 1);
        for (int i = 0; i < 60; i++) refb[i] = (i < 10) ? 8'(i + 1) : 8'h00;
        exp_fcs = ref_fcs(60);
        sel = 1'b0;
        send_frame(10, 1'b0, -1, 0, s, l);
        wait_cycles(100);
        begin
            int bad;
            chk("lat_c0_idle", en_log[s], 1'b0);
            chk("lat_c1_pre", {en_log[s+1], txd_log[s+1]}, {1'b1, 8'h55});
            chk("lat_sfd", {sp_log[s+8], en_log[s+8], txd_log[s+8]}, {1'b1, 1'b1, 8'hD5});
            chk("lat_first_byte", txd_log[s+9], 8'h01);
            chk("pad_len", count_sig(S_EN, s, s + 99), 72);
            chk("pad_contig", count_sig(S_EN, s + 1, s + 72), 72);
            bad = 0;
            for (int k = 1; k <= 7; k++) if (txd_log[s+k] !== 8'h55) bad++;
            chk("pad_preamble", bad, 0);
            bad = 0;
            for (int k = 0; k < 60; k++) if (txd_log[s+9+k] !== refb[k]) bad++;
            chk("pad_body", bad, 0);
            chk("pad_fcs", {txd_log[s+72], txd_log[s+71], txd_log[s+70], txd_log[s+69]}, exp_fcs);
            chk("pad_ifg_low", count_sig(S_EN, s + 73, s + 84), 0);
            chk("pad_er_none", count_sig(S_ER, s, s + 99), 0);
            chk("pad_sp_once", count_sig(S_SP, s, s + 99), 1);
        end

        // Known CRC on the non-padding instance: "123456789".
        sel = 1'b1;
        for (int i = 0; i < 9; i++) pl[i] = 8'(8'h31 + i);
        send_frame(9, 1'b0, -1, 0, s2, l2);
        wait_cycles(60);
        chk("crc_len", count_sig(S_EN, s2, s2 + 50), 21);
        chk("crc_last_payload", txd_log[s2+17], 8'h39);
        chk("crc_fcs", {txd_log[s2+21], txd_log[s2+20], txd_log[s2+19], txd_log[s2+18]},
            32'hCBF43926);
        sel = 1'b0;
        wait_cycles(2);

        // Underflow after 20 bytes, then an aborted frame and a normal frame
        // each offered as soon as the previous tlast is taken.
        for (int i = 0; i < 100; i++) pl[i] = 8'(i * 3 + 7);
        send_frame(100, 1'b0, 20, 3, s3, l3);
        for (int i = 0; i < 70; i++) pl[i] = 8'(8'h40 + i);
        send_frame(70, 1'b1, -1, 0, s4, l4);
        for (int i = 0; i < 10; i++) pl[i] = 8'(i + 1);
        send_frame(10, 1'b0, -1, 0, s5, l5);
        wait_cycles(100);

        chk("uf_pre_len", count_sig(S_EN, s3, s3 + 28), 28);
        chk("uf_last_good", txd_log[s3+28], 8'(19 * 3 + 7));
        chk("uf_cycle", {en_log[s3+29], er_log[s3+29], uf_log[s3+29], txd_log[s3+29]},
            {1'b1, 1'b1, 1'b1, 8'h00});
        chk("uf_quiet", count_sig(S_EN, s3 + 30, s4 + 13), 0);
        chk("uf_er_once", count_sig(S_ER, s3, s4 + 13), 1);
        chk("uf_pulse_once", count_sig(S_UF, s3, s4 + 13), 1);
        chk("uf_ifg_rdy", count_sig(S_RDY, s4, s4 + 12), 0);
        chk("uf_ifg_rise", first_en(s4, s4 + 40) - s4, 14);

        r = s4 + 14;
        chk("ab_len", count_sig(S_EN, r, r + 78), 78);
        chk("ab_er_before", count_sig(S_ER, r, r + 76), 0);
        chk("ab_last", {en_log[r+77], er_log[r+77], txd_log[r+77]}, {1'b1, 1'b1, 8'h85});
        chk("ab_fall", {en_log[r+78], er_log[r+78]}, {1'b0, 1'b0});
        chk("b2b_gap", first_en(r + 78, r + 140) - (r + 78), 13);

        r5 = r + 91;
        chk("b2b_len", count_sig(S_EN, r5, r5 + 90), 72);
        chk("b2b_fcs", {txd_log[r5+71], txd_log[r5+70], txd_log[r5+69], txd_log[r5+68]}, exp_fcs);

        // Asynchronous reset while payload byte 30 is on the wire.
        for (int i = 0; i < 64; i++) pl[i] = 8'(8'hA0 + i);
        acc = 0; guard = 0;
        tvalid = 1'b1; tlast = 1'b0; tuser = 1'b0; tdata = pl[0];
        while (acc < 30 && guard < 200) begin
            @(negedge clk);
            if (rdy) acc++;
            @(posedge clk);
            #1;
            tdata = pl[acc];
            guard++;
        end
        chk("rst_pre", {en, txd}, {1'b1, pl[29]});
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async", {en, er, sp, uf, rdy, txd}, 0);
        tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_hold", {en, er, sp, uf, rdy, txd}, 0);
        wait_cycles(3);

        // Frame after the reset must be complete with a correct FCS.
        for (int i = 0; i < 10; i++) pl[i] = 8'(i + 1);
        send_frame(10, 1'b0, -1, 0, s7, l7);
        wait_cycles(100);
        chk("post_rst_sfd", {sp_log[s7+8], txd_log[s7+8]}, {1'b1, 8'hD5});
        chk("post_rst_len", count_sig(S_EN, s7, s7 + 99), 72);
        chk("post_rst_fcs", {txd_log[s7+72], txd_log[s7+71], txd_log[s7+70], txd_log[s7+69]},
            exp_fcs);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
